sd_access_arbiter: RTL and testbench

//  Shares the single SD card controller between two block-read/write requesters
//  (e.g. BMP copier and file-system reader). Round-robin grant; one SD transaction
//  at a time. Latches block address and serial count per transaction.

---
 rtl/sd_access_arbiter.sv | 146 ++++++++++++++
 tb/tb_sd_access_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_access_arbiter.sv
// Round-robin arbiter sharing one SD controller between two block requesters,
// with per-transaction address/count latching, data-strobe routing and a watchdog.
module sd_access_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_enable,
  input  logic [63:0] req_addr_block,
  input  logic [63:0] req_serial_count,
  input  logic [63:0] req_in_data,
  output logic [1:0]  req_complite,
  output logic [1:0]  req_fail,
  output logic [1:0]  req_out_data_valid,
  output logic [1:0]  req_input_data_valid,
  output logic [1:0]  grant,
  output logic        timeout_pulse,
  input  logic        sd_init_complite,
  output logic        sd_enable,
  output logic [31:0] sd_addr_block,
  output logic [31:0] sd_serial_count,
  input  logic        sd_complite,
  input  logic        sd_fail,
  input  logic        sd_out_data_valid,
  input  logic        sd_input_data_valid,
  output logic [31:0] sd_input_data
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StActive  = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  complite_q, complite_d;
  logic [1:0]  fail_q, fail_d;
  logic        sd_enable_q, sd_enable_d;
  logic        timeout_q, timeout_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] count_q, count_d;
  logic [23:0] wd_q, wd_d;
  logic        last_q, last_d;
  logic        g;
  logic        pick;

  assign g = grant_q[1];

  // Reset last_q to 1 so requester 0 wins the first tie.
  always_comb begin
    if (req_enable == 2'b11) pick = ~last_q;
    else                     pick = req_enable[1];
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    complite_d  = complite_q;
    fail_d      = fail_q;
    sd_enable_d = sd_enable_q;
    timeout_d   = 1'b0;
    addr_d      = addr_q;
    count_d     = count_q;
    wd_d        = wd_q;
    last_d      = last_q;
    unique case (state_q)
      StIdle: begin
        if (sd_init_complite && (req_enable != 2'b00)) begin
          grant_d     = pick ? 2'b10 : 2'b01;
          addr_d      = pick ? req_addr_block[63:32] : req_addr_block[31:0];
          count_d     = pick ? req_serial_count[63:32] : req_serial_count[31:0];
          sd_enable_d = 1'b1;
          wd_d        = '0;
          state_d     = StActive;
        end
      end
      StActive: begin
        if (wd_q != '1) wd_d = wd_q + 24'd1;
        if (sd_fail) begin
          fail_d[g]   = 1'b1;
          sd_enable_d = 1'b0;
          state_d     = StRelease;
        end else if (sd_complite) begin
          complite_d[g] = 1'b1;
          sd_enable_d   = 1'b0;
          state_d       = StRelease;
        end else if (wd_q == TIMEOUT_CYCLES - 24'd1) begin
          fail_d[g]   = 1'b1;
          timeout_d   = 1'b1;
          sd_enable_d = 1'b0;
          state_d     = StRelease;
        end else if (!req_enable[g]) begin
          sd_enable_d = 1'b0;
          state_d     = StRelease;
        end
      end
      StRelease: begin
        if (!req_enable[g] && !sd_complite && !sd_fail) begin
          complite_d = 2'b00;
          fail_d     = 2'b00;
          grant_d    = 2'b00;
          last_d     = g;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= 2'b00;
      complite_q  <= 2'b00;
      fail_q      <= 2'b00;
      sd_enable_q <= 1'b0;
      timeout_q   <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      wd_q        <= '0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      complite_q  <= complite_d;
      fail_q      <= fail_d;
      sd_enable_q <= sd_enable_d;
      timeout_q   <= timeout_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      wd_q        <= wd_d;
      last_q      <= last_d;
    end
  end

  assign grant                = grant_q;
  assign req_complite         = complite_q;
  assign req_fail             = fail_q;
  assign sd_enable            = sd_enable_q;
  assign timeout_pulse        = timeout_q;
  assign sd_addr_block        = addr_q;
  assign sd_serial_count      = count_q;
  assign req_out_data_valid   = {2{sd_out_data_valid}} & grant_q;
  assign req_input_data_valid = {2{sd_input_data_valid}} & grant_q;
  assign sd_input_data        = grant_q[1] ? req_in_data[63:32] : req_in_data[31:0];

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Directed bench for sd_access_arbiter: arbitration, routing, status, watchdog and reset.
module tb_sd_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_enable;
  logic [63:0] req_addr_block;
  logic [63:0] req_serial_count;
  logic [63:0] req_in_data;
  logic [1:0]  req_complite;
  logic [1:0]  req_fail;
  logic [1:0]  req_out_data_valid;
  logic [1:0]  req_input_data_valid;
  logic [1:0]  grant;
  logic        timeout_pulse;
  logic        sd_init_complite;
  logic        sd_enable;
  logic [31:0] sd_addr_block;
  logic [31:0] sd_serial_count;
  logic        sd_complite;
  logic        sd_fail;
  logic        sd_out_data_valid;
  logic        sd_input_data_valid;
  logic [31:0] sd_input_data;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned cnt_hit1;
  int unsigned cnt_hit0;

  sd_access_arbiter #(
    .TIMEOUT_CYCLES(24'd100)
  ) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_enable          (req_enable),
    .req_addr_block      (req_addr_block),
    .req_serial_count    (req_serial_count),
    .req_in_data         (req_in_data),
    .req_complite        (req_complite),
    .req_fail            (req_fail),
    .req_out_data_valid  (req_out_data_valid),
    .req_input_data_valid(req_input_data_valid),
    .grant               (grant),
    .timeout_pulse       (timeout_pulse),
    .sd_init_complite    (sd_init_complite),
    .sd_enable           (sd_enable),
    .sd_addr_block       (sd_addr_block),
    .sd_serial_count     (sd_serial_count),
    .sd_complite         (sd_complite),
    .sd_fail             (sd_fail),
    .sd_out_data_valid   (sd_out_data_valid),
    .sd_input_data_valid (sd_input_data_valid),
    .sd_input_data       (sd_input_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_complite();
    sd_complite = 1'b1;
    tick(1);
    sd_complite = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    req_enable = 2'b00;
    req_addr_block = '0;
    req_serial_count = '0;
    req_in_data = '0;
    sd_init_complite = 1'b0;
    sd_complite = 1'b0;
    sd_fail = 1'b0;
    sd_out_data_valid = 1'b0;
    sd_input_data_valid = 1'b0;
    tick(2);
    check("rst_grant", {62'd0, grant}, 64'd0);
    check("rst_sd_enable", {63'd0, sd_enable}, 64'd0);
    check("rst_addr", {32'd0, sd_addr_block}, 64'd0);
    check("rst_status", {60'd0, req_complite, req_fail}, 64'd0);
    check("rst_timeout", {63'd0, timeout_pulse}, 64'd0);
    rst_n = 1'b1;
    sd_init_complite = 1'b1;
    tick(1);

    // T1: single requester, complete after 40 cycles
    req_addr_block   = {32'h0, 32'h10};
    req_serial_count = {32'h0, 32'h1};
    req_enable       = 2'b01;
    tick(1);
    check("t1_grant", {62'd0, grant}, 64'd1);
    check("t1_sd_enable", {63'd0, sd_enable}, 64'd1);
    check("t1_addr", {32'd0, sd_addr_block}, 64'h10);
    check("t1_count", {32'd0, sd_serial_count}, 64'h1);
    tick(40);
    pulse_complite();
    check("t1_complite", {62'd0, req_complite}, 64'd1);
    check("t1_sd_enable_off", {63'd0, sd_enable}, 64'd0);
    tick(3);
    check("t1_complite_held", {62'd0, req_complite}, 64'd1);
    check("t1_grant_held", {62'd0, grant}, 64'd1);
    req_enable = 2'b00;
    tick(1);
    check("t1_grant_idle", {62'd0, grant}, 64'd0);
    check("t1_complite_clr", {62'd0, req_complite}, 64'd0);

    // T2: simultaneous requests after a fresh reset -> req0 first
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    req_addr_block = {32'h200, 32'h100};
    req_enable     = 2'b11;
    tick(1);
    check("t2_first_req0", {62'd0, grant}, 64'd1);
    check("t2_addr0", {32'd0, sd_addr_block}, 64'h100);
    pulse_complite();
    req_enable = 2'b10;
    tick(1);
    check("t2_idle_gap", {62'd0, grant}, 64'd0);
    tick(1);
    check("t2_then_req1", {62'd0, grant}, 64'd2);
    check("t2_addr1", {32'd0, sd_addr_block}, 64'h200);

    // T3: routing while req1 owns the card
    req_in_data    = {32'hCAFEBABE, 32'h12345678};
    req_addr_block = {32'h999, 32'h100};
    tick(1);
    check("t3_in_data", {32'd0, sd_input_data}, 64'hCAFEBABE);
    check("t3_addr_stable", {32'd0, sd_addr_block}, 64'h200);
    cnt_hit1 = 0;
    cnt_hit0 = 0;
    for (int i = 0; i < 128; i++) begin
      sd_out_data_valid = 1'b1;
      tick(1);
      if (req_out_data_valid == 2'b10) cnt_hit1++;
      if (req_out_data_valid[0]) cnt_hit0++;
      sd_out_data_valid = 1'b0;
      tick(1);
      if (req_out_data_valid != 2'b00) cnt_hit0++;
    end
    check("t3_valid_req1", 64'(cnt_hit1), 64'd128);
    check("t3_valid_req0", 64'(cnt_hit0), 64'd0);
    sd_input_data_valid = 1'b1;
    tick(1);
    check("t3_in_valid", {62'd0, req_input_data_valid}, 64'd2);
    sd_input_data_valid = 1'b0;
    pulse_complite();
    req_enable = 2'b00;
    tick(2);

    // Last served was req1, so the next tie goes to req0, the one after to req1
    req_enable = 2'b11;
    tick(1);
    check("t2_tie_after_req1", {62'd0, grant}, 64'd1);
    pulse_complite();
    req_enable = 2'b00;
    tick(2);
    req_enable = 2'b11;
    tick(1);
    check("t2_tie_after_req0", {62'd0, grant}, 64'd2);

    // T4: fail and complete together resolve as fail; retry re-latches address
    req_enable  = 2'b10;
    sd_fail     = 1'b1;
    sd_complite = 1'b1;
    tick(1);
    sd_fail     = 1'b0;
    sd_complite = 1'b0;
    check("t4_fail", {62'd0, req_fail}, 64'd2);
    check("t4_no_complite", {62'd0, req_complite}, 64'd0);
    req_enable = 2'b00;
    tick(1);
    check("t4_fail_clr", {62'd0, req_fail}, 64'd0);
    req_addr_block = {32'h777, 32'h100};
    req_enable     = 2'b10;
    tick(1);
    check("t4_retry_grant", {62'd0, grant}, 64'd2);
    check("t4_retry_addr", {32'd0, sd_addr_block}, 64'h777);

    // T5: watchdog fires on the 100th ACTIVE cycle
    tick(99);
    check("t5_before_timeout", {62'd0, timeout_pulse, sd_enable}, 64'd1);
    tick(1);
    check("t5_timeout_pulse", {63'd0, timeout_pulse}, 64'd1);
    check("t5_fail", {62'd0, req_fail}, 64'd2);
    check("t5_sd_enable_off", {63'd0, sd_enable}, 64'd0);
    tick(1);
    check("t5_pulse_one_cycle", {63'd0, timeout_pulse}, 64'd0);
    check("t5_fail_held", {62'd0, req_fail}, 64'd2);
    req_enable = 2'b00;
    tick(1);

    // T6: no grant without card init, then async reset mid-transfer
    sd_init_complite = 1'b0;
    req_enable       = 2'b11;
    tick(3);
    check("t6_no_init_grant", {62'd0, grant}, 64'd0);
    check("t6_no_init_enable", {63'd0, sd_enable}, 64'd0);
    sd_init_complite = 1'b1;
    tick(1);
    check("t6_grant_after_init", {62'd0, grant}, 64'd1);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("t6_async_enable", {63'd0, sd_enable}, 64'd0);
    check("t6_async_grant", {62'd0, grant}, 64'd0);
    check("t6_async_addr", {32'd0, sd_addr_block}, 64'd0);
    tick(1);
    rst_n      = 1'b1;
    req_enable = 2'b00;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
